// File: rtl/alu_pipe_if.sv
// Command/result bundle for alu_pipe: operand/opcode handshake in, result/flags handshake out.
// The DUT uses the slave modport; the command source and result sink use the master modport.
interface alu_pipe_if #(
  parameter int DATA_IN_WIDTH = 8
);
  localparam int DATA_OUT_WIDTH = 2 * DATA_IN_WIDTH;

  logic [DATA_IN_WIDTH-1:0]  data_a_in;
  logic [DATA_IN_WIDTH-1:0]  data_b_in;
  logic [3:0]                alu_func_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_OUT_WIDTH-1:0] data_out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      carry_out;
  logic                      zero_out;
  logic                      div_by_zero_out;

  modport slave (
    input  data_a_in, data_b_in, alu_func_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, carry_out, zero_out, div_by_zero_out
  );

  modport master (
    output data_a_in, data_b_in, alu_func_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, carry_out, zero_out, div_by_zero_out
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with single-entry output slot and a multi-cycle restoring divider.
// Non-divide ops complete in one cycle; a divide occupies DATA_IN_WIDTH cycles in DIV.
module alu_pipe #(
  parameter int DATA_IN_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_pipe_if.slave  bus
);
  localparam int DATA_OUT_WIDTH = 2 * DATA_IN_WIDTH;
  localparam int CNT_WIDTH      = $clog2(DATA_IN_WIDTH + 1);
  localparam int N              = DATA_IN_WIDTH;
  localparam int W              = DATA_OUT_WIDTH;

  typedef enum logic {IDLE, DIV} state_e;

  state_e               state_q, state_d;
  logic [N-1:0]         acc_q, acc_d;
  logic [N-1:0]         divisor_q, divisor_d;
  logic [N-1:0]         rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;

  logic         accept;
  logic         is_div;
  logic [W-1:0] a_ext, b_ext;
  logic [N:0]   sum;
  logic [N-1:0] lo;
  logic [W-1:0] alu_res;
  logic         alu_carry;
  logic [N:0]   rem_shift, trial;
  logic         q_bit;
  logic [N-1:0] rem_step, acc_step;
  logic [W-1:0] div_res;

  assign bus.in_ready = reset_n & (state_q == IDLE) & (!valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign is_div       = (bus.alu_func_in == 4'b0011);

  always_comb begin
    a_ext     = {{N{1'b0}}, bus.data_a_in};
    b_ext     = {{N{1'b0}}, bus.data_b_in};
    sum       = {1'b0, bus.data_a_in} + {1'b0, bus.data_b_in};
    lo        = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.alu_func_in)
      4'b0000: begin
        alu_res[N:0] = sum;
        alu_carry    = sum[N];
      end
      4'b0001: begin
        alu_res   = a_ext - b_ext;
        alu_carry = (bus.data_a_in < bus.data_b_in);
      end
      4'b0010: alu_res = a_ext * b_ext;
      // Only reaches the slot for B == 0: operand A above an all-ones quotient.
      4'b0011: alu_res = {bus.data_a_in, {N{1'b1}}};
      4'b0100: alu_res = a_ext & b_ext;
      4'b0101: alu_res = a_ext | b_ext;
      4'b0110: begin
        lo              = ~(bus.data_a_in & bus.data_b_in);
        alu_res[N-1:0]  = lo;
      end
      4'b0111: begin
        lo              = ~(bus.data_a_in | bus.data_b_in);
        alu_res[N-1:0]  = lo;
      end
      4'b1000: alu_res = a_ext ^ b_ext;
      4'b1001: begin
        lo              = ~(bus.data_a_in ^ bus.data_b_in);
        alu_res[N-1:0]  = lo;
      end
      4'b1010: if (bus.data_a_in == bus.data_b_in) alu_res[1:0] = 2'd1;
      4'b1011: if (bus.data_a_in >  bus.data_b_in) alu_res[1:0] = 2'd2;
      4'b1100: if (bus.data_a_in <  bus.data_b_in) alu_res[1:0] = 2'd3;
      4'b1101: alu_res[N-1:0] = bus.data_a_in >> 1;
      4'b1110: alu_res[N:0]   = {bus.data_a_in, 1'b0};
      default: alu_res = '0;
    endcase
  end

  // Restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_shift = {rem_q, acc_q[N-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    q_bit     = ~trial[N];
    rem_step  = q_bit ? trial[N-1:0] : rem_shift[N-1:0];
    acc_step  = {acc_q[N-2:0], q_bit};
    div_res   = {rem_step, acc_step};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    valid_d   = valid_q & ~bus.out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_div && (bus.data_b_in != '0)) begin
            acc_d     = bus.data_a_in;
            divisor_d = bus.data_b_in;
            rem_d     = '0;
            cnt_d     = CNT_WIDTH'(N);
            state_d   = DIV;
          end else begin
            data_d  = alu_res;
            carry_d = alu_carry;
            zero_d  = (alu_res == '0);
            dbz_d   = is_div;
            valid_d = 1'b1;
          end
        end
      end
      DIV: begin
        acc_d = acc_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        // Accept required a free or draining slot, so the final step can load it directly.
        if (cnt_q == CNT_WIDTH'(1)) begin
          data_d  = div_res;
          carry_d = 1'b0;
          zero_d  = (div_res == '0);
          dbz_d   = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.data_out        = data_q;
  assign bus.out_valid       = valid_q;
  assign bus.carry_out       = carry_q;
  assign bus.zero_out        = zero_q;
  assign bus.div_by_zero_out = dbz_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed vectors, latency, back-pressure and mid-divide reset.
module tb_alu_pipe;
  logic clk;
  logic reset_n;
  int   checkCount;
  int   failCount;
  int   lowCnt;

  alu_pipe_if #(.DATA_IN_WIDTH(8)) bus ();

  alu_pipe #(.DATA_IN_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one command with out_ready high, then check result, flags and accept-to-valid latency.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [15:0] expData,
                               input logic expCarry, input logic expZero, input logic expDbz,
                               input int expLat, output int lowCount);
    int guard;
    int lat;
    @(negedge clk);
    bus.alu_func_in = op;
    bus.data_a_in   = a;
    bus.data_b_in   = b;
    bus.in_valid    = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput({tag, "_accept"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat      = 0;
    lowCount = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.in_ready) lowCount++;
    end while (!bus.out_valid && lat < 50);
    checkOutput({tag, "_lat"},   32'(lat),                 32'(expLat));
    checkOutput({tag, "_data"},  32'(bus.data_out),        32'(expData));
    checkOutput({tag, "_carry"}, 32'(bus.carry_out),       32'(expCarry));
    checkOutput({tag, "_zero"},  32'(bus.zero_out),        32'(expZero));
    checkOutput({tag, "_dbz"},   32'(bus.div_by_zero_out), 32'(expDbz));
  endtask

  logic [3:0]  sOp  [5] = '{4'h0, 4'h1, 4'h8, 4'h2, 4'h5};
  logic [7:0]  sA   [5] = '{8'h01, 8'h09, 8'hAA, 8'h10, 8'h0F};
  logic [7:0]  sB   [5] = '{8'h02, 8'h04, 8'h55, 8'h10, 8'hF0};
  logic [15:0] sExp [5] = '{16'h0003, 16'h0005, 16'h00FF, 16'h0100, 16'h00FF};

  initial begin
    int sawValid;
    checkCount      = 0;
    failCount       = 0;
    reset_n         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.data_a_in   = '0;
    bus.data_b_in   = '0;
    bus.alu_func_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_data",  32'(bus.data_out),  32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready),  32'd0);
    checkOutput("rst_flags", 32'({bus.carry_out, bus.zero_out, bus.div_by_zero_out}), 32'd0);
    reset_n = 1'b1;

    applyStimulus("add_ff01", 4'h0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("add_zero", 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1, lowCnt);
    applyStimulus("sub_0305", 4'h1, 8'h03, 8'h05, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("sub_0503", 4'h1, 8'h05, 8'h03, 16'h0002, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("mul_ffff", 4'h2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("and",      4'h4, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("nand",     4'h6, 8'hF0, 8'h3C, 16'h00CF, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("nor",      4'h7, 8'hF0, 8'h0F, 16'h0000, 1'b0, 1'b1, 1'b0, 1, lowCnt);
    applyStimulus("xnor",     4'h9, 8'hF0, 8'h3C, 16'h0033, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("eq",       4'hA, 8'h05, 8'h05, 16'h0001, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("gt",       4'hB, 8'h06, 8'h05, 16'h0002, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("lt_false", 4'hC, 8'h06, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0, 1, lowCnt);
    applyStimulus("lt",       4'hC, 8'h04, 8'h05, 16'h0003, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("shr",      4'hD, 8'h81, 8'h00, 16'h0040, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("shl",      4'hE, 8'h81, 8'h00, 16'h0102, 1'b0, 1'b0, 1'b0, 1, lowCnt);
    applyStimulus("rsvd",     4'hF, 8'hAB, 8'hCD, 16'h0000, 1'b0, 1'b1, 1'b0, 1, lowCnt);

    applyStimulus("div_200_7", 4'h3, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 9, lowCnt);
    checkOutput("div_ready_low", 32'(lowCnt), 32'd8);
    applyStimulus("div_9_0", 4'h3, 8'd9, 8'd0, 16'h09FF, 1'b0, 1'b0, 1'b1, 1, lowCnt);
    applyStimulus("div_0_5", 4'h3, 8'd0, 8'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 9, lowCnt);
    applyStimulus("div_255_16", 4'h3, 8'd255, 8'd16, 16'h0F0F, 1'b0, 1'b0, 1'b0, 9, lowCnt);

    // Back-pressure: the result must hold and block new commands until consumed.
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.alu_func_in = 4'h0;
    bus.data_a_in   = 8'd10;
    bus.data_b_in   = 8'd20;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_data_%0d", i),  32'(bus.data_out),  32'h001E);
      checkOutput($sformatf("hold_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("hold_ready_%0d", i), 32'(bus.in_ready),  32'd0);
    end

    // First stream command loads while the held result drains in the same cycle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.out_ready = 1'b1;
      if (k > 0) begin
        checkOutput($sformatf("stream_valid_%0d", k - 1), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("stream_data_%0d", k - 1),  32'(bus.data_out),  32'(sExp[k-1]));
      end
      bus.alu_func_in = sOp[k];
      bus.data_a_in   = sA[k];
      bus.data_b_in   = sB[k];
      bus.in_valid    = 1'b1;
      #1 checkOutput($sformatf("stream_ready_%0d", k), 32'(bus.in_ready), 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("stream_valid_4", 32'(bus.out_valid), 32'd1);
    checkOutput("stream_data_4",  32'(bus.data_out),  32'(sExp[4]));

    // Reset while the divider is at count 4 must discard the operation entirely.
    @(negedge clk);
    bus.alu_func_in = 4'h3;
    bus.data_a_in   = 8'd200;
    bus.data_b_in   = 8'd7;
    bus.in_valid    = 1'b1;
    #1 checkOutput("rstdiv_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rstdiv_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstdiv_data",  32'(bus.data_out),  32'd0);
    checkOutput("rstdiv_ready_in_rst", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    #1 checkOutput("rstdiv_ready_after", 32'(bus.in_ready), 32'd1);
    sawValid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.data_out != '0) sawValid++;
    end
    checkOutput("rstdiv_no_stale", 32'(sawValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
